// File: rtl/z80_bus_monitor_if.sv
// Pins of a tv80s core as seen by the bus monitor, plus the record stream it produces.
// master is the monitor's view; slave is the view of whoever drives the pins and consumes records.
interface z80_bus_monitor_if #(
  parameter int STAMP_W = 16
);
  logic               m1_n;
  logic               mreq_n;
  logic               iorq_n;
  logic               rd_n;
  logic               wr_n;
  logic               rfsh_n;
  logic [15:0]        A;
  logic [7:0]         di;
  logic [7:0]         dout;
  logic               rec_valid;
  logic               rec_ready;
  logic [2:0]         rec_kind;
  logic [15:0]        rec_addr;
  logic [7:0]         rec_data;
  logic [STAMP_W-1:0] rec_stamp;

  modport master (
    input  m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, A, di, dout, rec_ready,
    output rec_valid, rec_kind, rec_addr, rec_data, rec_stamp
  );

  modport slave (
    output m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, A, di, dout, rec_ready,
    input  rec_valid, rec_kind, rec_addr, rec_data, rec_stamp
  );
endinterface

// File: rtl/z80_bus_monitor.sv
// Passive tv80s bus observer: turns each completed bus cycle into a {kind, addr, data, stamp}
// record and queues it in a FIFO behind a valid/ready stream.
module z80_bus_monitor #(
  parameter int DEPTH   = 16,
  parameter int STAMP_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en,
  z80_bus_monitor_if.master      bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [7:0]             drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  localparam logic [2:0] K_FETCH   = 3'd0;
  localparam logic [2:0] K_MEM_RD  = 3'd1;
  localparam logic [2:0] K_MEM_WR  = 3'd2;
  localparam logic [2:0] K_IO_RD   = 3'd3;
  localparam logic [2:0] K_IO_WR   = 3'd4;
  localparam logic [2:0] K_INT_ACK = 3'd5;

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic [2:0]         kind;
    logic [15:0]        addr;
    logic [7:0]         data;
    logic [STAMP_W-1:0] stamp;
  } rec_t;

  state_t             state;
  logic [STAMP_W-1:0] stamp;
  rec_t               cur;
  rec_t               pend;
  rec_t               fresh;
  rec_t               head;
  logic               pend_valid;
  logic               head_valid;
  logic               int_ack;
  logic               bus_active;
  logic               same_cycle;
  logic [2:0]         kind_now;
  logic [7:0]         data_now;

  rec_t               mem [DEPTH];
  logic [AW-1:0]      wptr;
  logic [AW-1:0]      rptr;
  logic [AW-1:0]      rptr_next;
  logic [LW-1:0]      count;
  logic [LW-1:0]      count_after_pop;
  logic               pop;
  logic               full;
  logic               accept;

  // Interrupt acknowledge is recognised from M1+IORQ alone; refresh cycles never count.
  always_comb begin
    int_ack    = ~bus.m1_n & ~bus.iorq_n;
    bus_active = bus.rfsh_n &
                 (int_ack | ((~bus.mreq_n | ~bus.iorq_n) & (~bus.rd_n | ~bus.wr_n)));
    if (int_ack)                                    kind_now = K_INT_ACK;
    else if (~bus.m1_n & ~bus.mreq_n & ~bus.rd_n)   kind_now = K_FETCH;
    else if (~bus.mreq_n)                           kind_now = bus.wr_n ? K_MEM_RD : K_MEM_WR;
    else                                            kind_now = bus.wr_n ? K_IO_RD : K_IO_WR;
    data_now    = (kind_now == K_MEM_WR || kind_now == K_IO_WR) ? bus.dout : bus.di;
    same_cycle  = bus_active && (kind_now == cur.kind) && (bus.A == cur.addr);
    fresh.kind  = kind_now;
    fresh.addr  = bus.A;
    fresh.data  = data_now;
    fresh.stamp = stamp;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stamp <= '0;
    else          stamp <= stamp + 1'b1;
  end

  // en only gates the opening of a cycle; an open cycle runs to its natural end.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cur        <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
    end else begin
      pend_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (en && bus_active) begin
            state <= BUSY;
            cur   <= fresh;
          end
        end
        BUSY: begin
          if (same_cycle) begin
            cur.data <= data_now;
          end else begin
            pend       <= cur;
            pend_valid <= 1'b1;
            if (en && bus_active) cur   <= fresh;
            else                  state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    pop             = head_valid & bus.rec_ready;
    full            = (count == FULL_LEVEL);
    accept          = pend_valid & (~full | pop);
    rptr_next       = rptr + AW'(pop);
    count_after_pop = count - LW'(pop);
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wptr] <= pend;
  end

  // The output register preloads the entry that will be at the head after this clock's pop,
  // so a freshly pushed record only appears one clock later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      head       <= '0;
      head_valid <= 1'b0;
      overflow   <= 1'b0;
      drop_cnt   <= 8'd0;
    end else begin
      if (accept) wptr <= wptr + 1'b1;
      rptr  <= rptr_next;
      count <= count_after_pop + LW'(accept);
      if (count_after_pop != '0) begin
        head_valid <= 1'b1;
        head       <= mem[rptr_next];
      end else begin
        head_valid <= 1'b0;
        head       <= '0;
      end
      if (pend_valid && full && !pop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  assign bus.rec_valid = head_valid;
  assign bus.rec_kind  = head.kind;
  assign bus.rec_addr  = head.addr;
  assign bus.rec_data  = head.data;
  assign bus.rec_stamp = head.stamp;
  assign level         = count;
endmodule
